// File: rtl/des_pkg.sv
// Shared DES constants: permutation tables, S-boxes, key-schedule shifts, FSM states.
// The forward key schedule table is consumed only when DES_ENCRYPT_MODE_EN is defined.
package des_pkg;

    localparam int BLK_W  = 64;
    localparam int KEY_W  = 56;
    localparam int HALF_W = 32;
    localparam int SUB_W  = 48;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_ROUND = 2'd1;
    localparam state_t S_DONE  = 2'd2;

    // Tables use DES 1-based bit numbers; DES bit n lives at vector bit W-n.
    localparam int IP_T [64] = '{
        58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
        62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
        57,49,41,33,25,17, 9,1, 59,51,43,35,27,19,11,3,
        61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{
        40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
        38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
        36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
        34,2,42,10,50,18,58,26, 33,1,41, 9,49,17,57,25};
    localparam int E_T [48] = '{
        32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9,10,11,12,13,
        12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25,
        24,25,26,27,28,29, 28,29,30,31,32, 1};
    localparam int P_T [32] = '{
        16, 7,20,21,29,12,28,17,  1,15,23,26, 5,18,31,10,
         2, 8,24,14,32,27, 3, 9, 19,13,30, 6,22,11, 4,25};
    localparam int PC1_T [56] = '{
        57,49,41,33,25,17, 9,  1,58,50,42,34,26,18,
        10, 2,59,51,43,35,27, 19,11, 3,60,52,44,36,
        63,55,47,39,31,23,15,  7,62,54,46,38,30,22,
        14, 6,61,53,45,37,29, 21,13, 5,28,20,12, 4};
    localparam int PC2_T [48] = '{
        14,17,11,24, 1, 5,  3,28,15, 6,21,10, 23,19,12, 4,26, 8,
        16, 7,27,20,13, 2, 41,52,31,37,47,55, 30,40,51,45,33,48,
        44,49,39,56,34,53, 46,42,50,36,29,32};

    localparam int SHIFT_DEC [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int SHIFT_ENC [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    localparam int SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[63-i] = x[64-IP_T[i]];
        return o;
    endfunction

    function automatic logic [63:0] fp(input logic [63:0] x);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[63-i] = x[64-FP_T[i]];
        return o;
    endfunction

    function automatic logic [47:0] e_exp(input logic [31:0] x);
        logic [47:0] o;
        for (int i = 0; i < 48; i++) o[47-i] = x[32-E_T[i]];
        return o;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] o;
        for (int i = 0; i < 32; i++) o[31-i] = x[32-P_T[i]];
        return o;
    endfunction

    function automatic logic [55:0] pc1(input logic [63:0] x);
        logic [55:0] o;
        for (int i = 0; i < 56; i++) o[55-i] = x[64-PC1_T[i]];
        return o;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] x);
        logic [47:0] o;
        for (int i = 0; i < 48; i++) o[47-i] = x[56-PC2_T[i]];
        return o;
    endfunction

    // Row from the outer bits, column from the inner four.
    function automatic logic [3:0] sbox(input int j, input logic [5:0] x);
        return 4'(SBOX[j][{x[5], x[0], x[4:1]}]);
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input int n);
        case (n)
            1:       return {x[0], x[27:1]};
            2:       return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input int n);
        case (n)
            1:       return {x[26:0], x[27]};
            2:       return {x[25:0], x[27:26]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/des_round_f.sv
// DES round function f(R,K) = P(S1..S8(E(R) ^ K)), purely combinational.
module des_round_f
    import des_pkg::*;
(
    input  logic [HALF_W-1:0] r,
    input  logic [SUB_W-1:0]  k,
    output logic [HALF_W-1:0] f
);
    logic [SUB_W-1:0]  x;
    logic [HALF_W-1:0] s;

    assign x = e_exp(r) ^ k;

    des_s1 u_s1 (.x(x[47:42]), .y(s[31:28]));
    des_s2 u_s2 (.x(x[41:36]), .y(s[27:24]));
    des_s3 u_s3 (.x(x[35:30]), .y(s[23:20]));
    des_s4 u_s4 (.x(x[29:24]), .y(s[19:16]));
    des_s5 u_s5 (.x(x[23:18]), .y(s[15:12]));
    des_s6 u_s6 (.x(x[17:12]), .y(s[11:8]));
    des_s7 u_s7 (.x(x[11:6]),  .y(s[7:4]));
    des_s8 u_s8 (.x(x[5:0]),   .y(s[3:0]));

    assign f = p_perm(s);
endmodule

// File: rtl/des_sbox.sv
// DES substitution boxes S1..S8: 6-bit group in (MSB = first bit), 4-bit value out.
module des_s1 import des_pkg::*; (input logic [5:0] x, output logic [3:0] y);
    assign y = sbox(0, x);
endmodule

module des_s2 import des_pkg::*; (input logic [5:0] x, output logic [3:0] y);
    assign y = sbox(1, x);
endmodule

module des_s3 import des_pkg::*; (input logic [5:0] x, output logic [3:0] y);
    assign y = sbox(2, x);
endmodule

module des_s4 import des_pkg::*; (input logic [5:0] x, output logic [3:0] y);
    assign y = sbox(3, x);
endmodule

module des_s5 import des_pkg::*; (input logic [5:0] x, output logic [3:0] y);
    assign y = sbox(4, x);
endmodule

module des_s6 import des_pkg::*; (input logic [5:0] x, output logic [3:0] y);
    assign y = sbox(5, x);
endmodule

module des_s7 import des_pkg::*; (input logic [5:0] x, output logic [3:0] y);
    assign y = sbox(6, x);
endmodule

module des_s8 import des_pkg::*; (input logic [5:0] x, output logic [3:0] y);
    assign y = sbox(7, x);
endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption, one Feistel round per clock; reverse key schedule.
// DES_ENCRYPT_MODE_EN adds an 'encrypt' input selecting the forward schedule.
module des_decrypt_iter
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef DES_ENCRYPT_MODE_EN
    input  logic             encrypt,
`endif
    input  logic [BLK_W-1:0] data_in,
    input  logic [BLK_W-1:0] key_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] data_out,
    output logic             busy
);
    localparam int RW = $clog2(NUM_ROUNDS + 1);

    state_t            state;
    logic [HALF_W-1:0] l, r, fo;
    logic [27:0]       c, d, c_nx, d_nx;
    logic [SUB_W-1:0]  subkey;
    logic [RW-1:0]     rnd;
    logic [3:0]        sidx;

    assign sidx      = 4'(rnd - 1'b1);
    assign in_ready  = rst_n && (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_ROUND);

`ifdef DES_ENCRYPT_MODE_EN
    logic enc;
    always_comb begin
        c_nx = rotr(c, SHIFT_DEC[sidx]);
        d_nx = rotr(d, SHIFT_DEC[sidx]);
        if (enc) begin
            c_nx = rotl(c, SHIFT_ENC[sidx]);
            d_nx = rotl(d, SHIFT_ENC[sidx]);
        end
    end
`else
    // Round 1 shifts by zero, so it keys off PC1 directly: K16.
    always_comb begin
        c_nx = rotr(c, SHIFT_DEC[sidx]);
        d_nx = rotr(d, SHIFT_DEC[sidx]);
    end
`endif

    assign subkey = pc2({c_nx, d_nx});

    des_round_f u_f (.r(r), .k(subkey), .f(fo));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            l        <= '0;
            r        <= '0;
            c        <= '0;
            d        <= '0;
            rnd      <= '0;
            data_out <= '0;
`ifdef DES_ENCRYPT_MODE_EN
            enc      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    {l, r}   <= ip(data_in);
                    {c, d}   <= pc1(key_in);
                    rnd      <= RW'(1);
                    state    <= S_ROUND;
`ifdef DES_ENCRYPT_MODE_EN
                    enc      <= encrypt;
`endif
                end
                S_ROUND: begin
                    l <= r;
                    r <= l ^ fo;
                    c <= c_nx;
                    d <= d_nx;
                    if (rnd == RW'(NUM_ROUNDS)) begin
                        // Final swap undone: output is FP(R16 || L16).
                        data_out <= fp({l ^ fo, r});
                        state    <= S_DONE;
                    end else begin
                        rnd <= rnd + 1'b1;
                    end
                end
                S_DONE: if (out_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_des_decrypt_iter.sv
// Directed bench for des_decrypt_iter using known DES vectors.
module tb_des_decrypt_iter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, encrypt = 1'b0;
    logic        in_ready, out_valid, busy;
    logic [63:0] data_in = '0, key_in = '0, data_out;
    int          n_chk = 0, n_fail = 0;
    int          cyc;

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] C1 = 64'h85E813540F0AB405;
    localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] C2 = 64'h0000000000000000;
    localparam logic [63:0] P2 = 64'h8787878787878787;
    localparam logic [63:0] PAR = 64'h0101010101010101;

    always #5 clk = ~clk;

    des_decrypt_iter #(.NUM_ROUNDS(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
`ifdef DES_ENCRYPT_MODE_EN
        .encrypt(encrypt),
`endif
        .data_in(data_in), .key_in(key_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 64) begin step(); n++; end
        check("in_ready_wait", 64'(in_ready), 64'd1);
    endtask

    // Counts the cycle index (handshake cycle = 0) at which out_valid appears.
    task automatic wait_out(output int c);
        c = 1;
        while (!out_valid && c < 64) begin step(); c++; end
    endtask

    task automatic run(input logic [63:0] k, input logic [63:0] din, input logic [63:0] exp);
        key_in = k; data_in = din; in_valid = 1'b1;
        wait_ready();
        step();
        in_valid = 1'b0;
        check("busy_round", 64'(busy), 64'd1);
        wait_out(cyc);
        check("latency", 64'(cyc), 64'd17);
        check("data_out", data_out, exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("out_valid_clr", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_data_out", data_out, 64'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        check("idle_in_ready", 64'(in_ready), 64'd1);

        run(K1, C1, P1);
        run(K2, C2, P2);
        run(K2 ^ PAR, C2, P2);

        // Output stall: data held, new input ignored until drained.
        key_in = K1; data_in = C1; in_valid = 1'b1;
        wait_ready();
        step();
        key_in = K2; data_in = C2;
        wait_out(cyc);
        check("stall_latency", 64'(cyc), 64'd17);
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_data", data_out, P1);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("stall_idle", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check("stall_accept", 64'(busy), 64'd1);
        wait_out(cyc);
        check("stall2_latency", 64'(cyc), 64'd17);
        check("stall2_data", data_out, P2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset during round 7.
        key_in = K1; data_in = C1; in_valid = 1'b1;
        wait_ready();
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_data_out", data_out, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_ready", 64'(in_ready), 64'd1);
        run(K1, C1, P1);

        // Back-to-back with in_valid and out_ready held high.
        out_ready = 1'b1;
        key_in = K1; data_in = C1; in_valid = 1'b1;
        wait_ready();
        step();
        key_in = K2; data_in = C2;
        wait_out(cyc);
        check("b2b_a_latency", 64'(cyc), 64'd17);
        check("b2b_a_data", data_out, P1);
        step();
        check("b2b_gap_valid", 64'(out_valid), 64'd0);
        check("b2b_gap_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check("b2b_b_accept", 64'(busy), 64'd1);
        wait_out(cyc);
        check("b2b_b_latency", 64'(cyc), 64'd17);
        check("b2b_b_data", data_out, P2);
        step();
        out_ready = 1'b0;

`ifdef DES_ENCRYPT_MODE_EN
        encrypt = 1'b1;
        run(K1, P1, C1);
        encrypt = 1'b0;
        run(K1, C1, P1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
